// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl
// Branch predictor and redirect controller for the fetch PC mux. A table of
// 2-bit saturating counters, indexed by the branch PC, gives a taken/not-taken
// guess in ID. The predicted branch is carried into EX, checked against the
// resolved outcome, and on a miss the block produces the corrected PC, the
// IF/ID and ID/EX squashes, and counts the miss. Statistics saturate.
module branch_predict_ctrl #(
    parameter int INST_ADDR_WIDTH = 32,
    parameter int BHT_ENTRIES     = 64,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_ID,
    input  logic                       is_branch_ID,
    input  logic [INST_ADDR_WIDTH-1:0] PC_ID,
    input  logic [INST_ADDR_WIDTH-1:0] branch_target_ID,
    input  logic                       early_jal_ID,
    input  logic                       meet_jalr_EX,
    input  logic                       branch_taken_EX,
    output logic                       predict_branch_taken_ID,
    output logic [INST_ADDR_WIDTH-1:0] predict_branch_taken_PC_ID,
    output logic                       fix_predict_EX,
    output logic [INST_ADDR_WIDTH-1:0] fix_predict_PC_EX,
    output logic                       flush_IF_ID,
    output logic                       flush_ID_EX,
    output logic [CNT_WIDTH-1:0]       branch_cnt,
    output logic [CNT_WIDTH-1:0]       mispredict_cnt
);

    // Word-aligned PCs: the two low bits carry no information, so the
    // table index starts at bit 2.
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [1:0] CNT_WEAK_NT = 2'b01;
    localparam logic [1:0] CNT_MAX     = 2'b11;
    localparam logic [1:0] CNT_MIN     = 2'b00;

    // Counter table
    logic [1:0] bht_q [BHT_ENTRIES];
    logic [1:0] bhtEntry_d;

    // Branch currently in EX
    logic                       exValid_q, exValid_d;
    logic                       exPred_q, exPred_d;
    logic [INST_ADDR_WIDTH-1:0] exPc_q, exPc_d;
    logic [INST_ADDR_WIDTH-1:0] exTarget_q, exTarget_d;

    // Statistics
    logic [CNT_WIDTH-1:0] branchCnt_q, branchCnt_d;
    logic [CNT_WIDTH-1:0] mispredictCnt_q, mispredictCnt_d;

    // Unqualified versions of the outputs, before the reset gating
    logic                       fixRaw;
    logic                       flushIdExRaw;
    logic                       flushIfIdRaw;
    logic                       predRaw;
    logic [INST_ADDR_WIDTH-1:0] exPcPlus4;
    logic [INST_ADDR_WIDTH-1:0] fixPcRaw;

    logic [IDX_W-1:0] idxId;
    logic [IDX_W-1:0] idxEx;

    // Only the index bits of PC_ID select the counter; the rest are carried
    // into EX through exPc_q, so every bit of the port is consumed.
    logic unusedPcId;
    assign unusedPcId = ^PC_ID;

    assign idxId = PC_ID[IDX_W+1:2];
    assign idxEx = exPc_q[IDX_W+1:2];

    // Resolution, redirect and prediction. The EX redirect is computed first
    // because a flush of ID/EX kills the branch sitting in ID, so that branch
    // must not redirect fetch on its own. The +4 wraps naturally at the
    // register width.
    always_comb begin
        exPcPlus4    = exPc_q + INST_ADDR_WIDTH'(4);
        fixRaw       = exValid_q & (exPred_q != branch_taken_EX);
        flushIdExRaw = fixRaw | meet_jalr_EX;
        predRaw      = is_branch_ID & ~stall_ID & ~flushIdExRaw & bht_q[idxId][1];
        flushIfIdRaw = flushIdExRaw | early_jal_ID | predRaw;
        fixPcRaw     = '0;
        if (exValid_q) begin
            fixPcRaw = branch_taken_EX ? exTarget_q : exPcPlus4;
        end
    end

    // Output gating: nothing leaves the block while reset is held, even if
    // the EX register still holds a branch from before reset. With no valid
    // branch in EX the correction bus is parked at zero.
    always_comb begin
        predict_branch_taken_ID    = ~rst & predRaw;
        predict_branch_taken_PC_ID = branch_target_ID;
        fix_predict_EX             = ~rst & fixRaw;
        fix_predict_PC_EX          = rst ? '0 : fixPcRaw;
        flush_ID_EX                = ~rst & flushIdExRaw;
        flush_IF_ID                = ~rst & flushIfIdRaw;
        branch_cnt                 = branchCnt_q;
        mispredict_cnt             = mispredictCnt_q;
    end

    // Next value of the EX tracking register: a flush or a stall puts a
    // bubble into EX, otherwise the ID instruction moves forward.
    always_comb begin
        exValid_d  = exValid_q;
        exPred_d   = exPred_q;
        exPc_d     = exPc_q;
        exTarget_d = exTarget_q;
        if (flushIdExRaw || stall_ID) begin
            exValid_d = 1'b0;
        end else begin
            exValid_d  = is_branch_ID;
            exPred_d   = predRaw;
            exPc_d     = PC_ID;
            exTarget_d = branch_target_ID;
        end
    end

    // EX tracking register
    always_ff @(posedge clk) begin
        if (rst) begin
            exValid_q  <= 1'b0;
            exPred_q   <= 1'b0;
            exPc_q     <= '0;
            exTarget_q <= '0;
        end else begin
            exValid_q  <= exValid_d;
            exPred_q   <= exPred_d;
            exPc_q     <= exPc_d;
            exTarget_q <= exTarget_d;
        end
    end

    // Saturating step of the counter owned by the branch in EX
    always_comb begin
        bhtEntry_d = bht_q[idxEx];
        if (branch_taken_EX) begin
            if (bht_q[idxEx] != CNT_MAX) begin
                bhtEntry_d = bht_q[idxEx] + 2'b01;
            end
        end else begin
            if (bht_q[idxEx] != CNT_MIN) begin
                bhtEntry_d = bht_q[idxEx] - 2'b01;
            end
        end
    end

    // Counter table: all entries start weakly not-taken; only a valid EX
    // branch trains its entry. No bypass to the ID read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_WEAK_NT;
            end
        end else if (exValid_q) begin
            bht_q[idxEx] <= bhtEntry_d;
        end
    end

    // Statistics next state: saturate at all-ones instead of wrapping
    always_comb begin
        branchCnt_d     = branchCnt_q;
        mispredictCnt_d = mispredictCnt_q;
        if (exValid_q && (branchCnt_q != {CNT_WIDTH{1'b1}})) begin
            branchCnt_d = branchCnt_q + CNT_WIDTH'(1);
        end
        if (fixRaw && (mispredictCnt_q != {CNT_WIDTH{1'b1}})) begin
            mispredictCnt_d = mispredictCnt_q + CNT_WIDTH'(1);
        end
    end

    // Statistics registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCnt_q     <= '0;
            mispredictCnt_q <= '0;
        end else begin
            branchCnt_q     <= branchCnt_d;
            mispredictCnt_q <= mispredictCnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Testbench for branch_predict_ctrl. A behavioural model (integer counter
// table, integer statistics, one EX slot) predicts every output each cycle;
// directed steps walk the interesting scenarios, then random traffic follows.
module tb_branch_predict_ctrl;

    localparam int AW      = 32;
    localparam int ENTRIES = 64;
    localparam int CW      = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          stall_ID;
    logic          is_branch_ID;
    logic [AW-1:0] PC_ID;
    logic [AW-1:0] branch_target_ID;
    logic          early_jal_ID;
    logic          meet_jalr_EX;
    logic          branch_taken_EX;
    logic          predict_branch_taken_ID;
    logic [AW-1:0] predict_branch_taken_PC_ID;
    logic          fix_predict_EX;
    logic [AW-1:0] fix_predict_PC_EX;
    logic          flush_IF_ID;
    logic          flush_ID_EX;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    branch_predict_ctrl #(
        .INST_ADDR_WIDTH(AW),
        .BHT_ENTRIES(ENTRIES),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_ID(stall_ID),
        .is_branch_ID(is_branch_ID),
        .PC_ID(PC_ID),
        .branch_target_ID(branch_target_ID),
        .early_jal_ID(early_jal_ID),
        .meet_jalr_EX(meet_jalr_EX),
        .branch_taken_EX(branch_taken_EX),
        .predict_branch_taken_ID(predict_branch_taken_ID),
        .predict_branch_taken_PC_ID(predict_branch_taken_PC_ID),
        .fix_predict_EX(fix_predict_EX),
        .fix_predict_PC_EX(fix_predict_PC_EX),
        .flush_IF_ID(flush_IF_ID),
        .flush_ID_EX(flush_ID_EX),
        .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state
    int          mBht [ENTRIES];
    int          mBranchCnt;
    int          mMissCnt;
    bit          mExValid;
    bit          mExPred;
    logic [31:0] mExPc;
    logic [31:0] mExTarget;

    // Last observed outputs for the directed spot checks
    logic        lastPred;
    logic [31:0] lastPredPc;
    logic        lastFix;
    logic [31:0] lastFixPc;
    logic        lastFlushIfId;
    logic        lastFlushIdEx;
    logic [31:0] lastBranchCnt;
    logic [31:0] lastMissCnt;

    function automatic int tableIndex(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) mBht[i] = 1;
        mBranchCnt = 0;
        mMissCnt   = 0;
        mExValid   = 0;
        mExPred    = 0;
        mExPc      = '0;
        mExTarget  = '0;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model for the inputs now applied
    task automatic checkOutput(input bit expPred, input bit expFix, input bit expFlushIdEx,
                               input bit expFlushIfId, input logic [31:0] expFixPc,
                               input bit fixPcKnown);
        lastPred      = predict_branch_taken_ID;
        lastPredPc    = predict_branch_taken_PC_ID;
        lastFix       = fix_predict_EX;
        lastFixPc     = fix_predict_PC_EX;
        lastFlushIfId = flush_IF_ID;
        lastFlushIdEx = flush_ID_EX;
        lastBranchCnt = 32'(branch_cnt);
        lastMissCnt   = 32'(mispredict_cnt);
        checkVal("predict", 32'(predict_branch_taken_ID), 32'(expPred));
        checkVal("predict_pc", predict_branch_taken_PC_ID, branch_target_ID);
        checkVal("fix", 32'(fix_predict_EX), 32'(expFix));
        checkVal("flush_id_ex", 32'(flush_ID_EX), 32'(expFlushIdEx));
        checkVal("flush_if_id", 32'(flush_IF_ID), 32'(expFlushIfId));
        checkVal("branch_cnt", 32'(branch_cnt), 32'(mBranchCnt));
        checkVal("mispredict_cnt", 32'(mispredict_cnt), 32'(mMissCnt));
        if (fixPcKnown) checkVal("fix_pc", fix_predict_PC_EX, expFixPc);
    endtask

    // One clock cycle: drive at the falling edge, check just after, then
    // advance the model across the rising edge.
    task automatic applyStimulus(input bit r, input bit st, input bit br,
                                 input logic [31:0] pc, input logic [31:0] tg,
                                 input bit jal, input bit jalr, input bit tk);
        bit          expFix, expFlushIdEx, expFlushIfId, expPred;
        logic [31:0] expFixPc;
        int          ix;
        rst              = r;
        stall_ID         = st;
        is_branch_ID     = br;
        PC_ID            = pc;
        branch_target_ID = tg;
        early_jal_ID     = jal;
        meet_jalr_EX     = jalr;
        branch_taken_EX  = tk;
        #1;
        expFix       = !r && mExValid && (mExPred != tk);
        expFlushIdEx = !r && (expFix || jalr);
        expPred      = !r && br && !st && !expFlushIdEx && (mBht[tableIndex(pc)] >= 2);
        expFlushIfId = !r && (expFlushIdEx || jal || expPred);
        expFixPc     = tk ? mExTarget : (mExPc + 32'd4);
        checkOutput(expPred, expFix, expFlushIdEx, expFlushIfId, expFixPc, !r && mExValid);
        if (r) begin
            modelReset();
        end else begin
            if (mExValid) begin
                ix = tableIndex(mExPc);
                mBht[ix]   = tk ? ((mBht[ix] < 3) ? mBht[ix] + 1 : 3)
                                : ((mBht[ix] > 0) ? mBht[ix] - 1 : 0);
                mBranchCnt = (mBranchCnt < CNT_SAT) ? mBranchCnt + 1 : CNT_SAT;
                if (expFix) mMissCnt = (mMissCnt < CNT_SAT) ? mMissCnt + 1 : CNT_SAT;
            end
            if (expFlushIdEx || st) begin
                mExValid = 0;
            end else begin
                mExValid  = br;
                mExPred   = expPred;
                mExPc     = pc;
                mExTarget = tg;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit tk);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0, tk);
    endtask

    logic [31:0] pcPool [6];
    logic [31:0] rPc;

    initial begin
        rst = 1'b1; stall_ID = 0; is_branch_ID = 0; PC_ID = '0; branch_target_ID = '0;
        early_jal_ID = 0; meet_jalr_EX = 0; branch_taken_EX = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held, then first cycle after reset
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        idle(0);
        checkVal("reset_fix", 32'(lastFix), 32'd0);

        // Cold branch predicted not-taken, resolves taken
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        checkVal("cold_predict", 32'(lastPred), 32'd0);
        checkVal("cold_flush_if_id", 32'(lastFlushIfId), 32'd0);
        idle(1);
        checkVal("cold_fix", 32'(lastFix), 32'd1);
        checkVal("cold_fix_pc", lastFixPc, 32'h80);
        checkVal("cold_flushes", 32'({lastFlushIfId, lastFlushIdEx}), 32'd3);
        idle(0);
        checkVal("cold_miss_cnt", lastMissCnt, 32'd1);

        // Two more taken occurrences saturate the counter
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
            idle(1);
        end
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        checkVal("trained_predict", 32'(lastPred), 32'd1);
        checkVal("trained_pred_pc", lastPredPc, 32'h80);
        idle(1);
        checkVal("trained_no_fix", 32'(lastFix), 32'd0);

        // Loop exit: one not-taken, counter drops to 10 and still predicts taken
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        idle(0);
        checkVal("exit_fix", 32'(lastFix), 32'd1);
        checkVal("exit_fix_pc", lastFixPc, 32'h104);
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        checkVal("exit_still_taken", 32'(lastPred), 32'd1);
        idle(1);

        // Aliasing: 0x200 shares the counter of 0x100
        applyStimulus(0, 0, 1, 32'h200, 32'h300, 0, 0, 0);
        checkVal("alias_predict", 32'(lastPred), 32'd1);
        idle(1);

        // Stalled branch never reaches EX
        applyStimulus(0, 1, 1, 32'h100, 32'h80, 0, 0, 0);
        checkVal("stall_predict", 32'(lastPred), 32'd0);
        idle(1);
        checkVal("stall_no_fix", 32'(lastFix), 32'd0);

        // Miss in EX coincident with a JAL and a strongly-taken branch in ID
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 1, 0, 0);
        checkVal("simul_fix", 32'(lastFix), 32'd1);
        checkVal("simul_predict", 32'(lastPred), 32'd0);
        checkVal("simul_flushes", 32'({lastFlushIfId, lastFlushIdEx}), 32'd3);

        // Wrap of the fall-through PC at the top of the address space
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 0, 1, 32'h000000FC, 32'h10, 0, 0, 0);
            idle(1);
        end
        applyStimulus(0, 0, 1, 32'hFFFFFFFC, 32'h10, 0, 0, 0);
        checkVal("wrap_predict", 32'(lastPred), 32'd1);
        idle(0);
        checkVal("wrap_fix", 32'(lastFix), 32'd1);
        checkVal("wrap_fix_pc", lastFixPc, 32'h0);

        // Statistics saturate at all-ones
        for (int k = 0; k < 17; k++) begin
            applyStimulus(0, 0, 1, 32'h40, 32'h20, 0, 0, 0);
            idle(k[0]);
        end
        idle(0);
        checkVal("branch_cnt_sat", lastBranchCnt, 32'd15);

        // Reset during the resolving cycle discards the branch
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        idle(0);
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 1);
        idle(0);
        checkVal("rst_branch_cnt", lastBranchCnt, 32'd0);
        checkVal("rst_miss_cnt", lastMissCnt, 32'd0);
        applyStimulus(0, 0, 1, 32'h100, 32'h80, 0, 0, 0);
        checkVal("rst_bht_untrained", 32'(lastPred), 32'd0);
        idle(0);

        // Random traffic over a small PC pool to force counter reuse
        pcPool[0] = 32'h100; pcPool[1] = 32'h200; pcPool[2] = 32'h104;
        pcPool[3] = 32'h10C; pcPool[4] = 32'hFFFFFFFC; pcPool[5] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            rPc = pcPool[$urandom_range(0, 5)];
            if (rPc == 32'h0) rPc = {$urandom()} & 32'hFFFFFFFC;
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 2) != 0),
                          rPc, {$urandom()} & 32'hFFFFFFFC,
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 9) == 0),
                          1'($urandom_range(0, 1)));
        end
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
